// File: rtl/ram_scan_pkg.sv
// Shared types for the RAM scanner: scan-mode encoding used by the sequencer and the top.
package ram_scan_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_STEP = 2'b11
    } mode_e;

endpackage

// File: rtl/scan_addr_seq.sv
// Read-address sequencer: holds rd_addr, the step edge detector and the wrap pulse.
// Wrap points are compared against DEPTH-1 so non-power-of-two depths scan correctly.
module scan_addr_seq
    import ram_scan_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              addr_clk,
    input  logic              reset,
    input  mode_e             mode,
    input  logic              step,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic              step_q;
    logic              go_up;
    logic              go_down;
    logic [ADDR_W-1:0] addr_next;
    logic              wrap_next;

    // STEP only advances on a rising step edge, so a step already high on entry is ignored.
    assign go_up   = (mode == MODE_UP) || ((mode == MODE_STEP) && step && !step_q);
    assign go_down = (mode == MODE_DOWN);

    always_comb begin
        addr_next = rd_addr;
        wrap_next = 1'b0;
        if (go_up) begin
            if (rd_addr == LAST_ADDR) begin
                addr_next = '0;
                wrap_next = 1'b1;
            end else begin
                addr_next = rd_addr + ADDR_W'(1);
            end
        end else if (go_down) begin
            if (rd_addr == '0) begin
                addr_next = LAST_ADDR;
                wrap_next = 1'b1;
            end else begin
                addr_next = rd_addr - ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge addr_clk) begin
        if (reset) begin
            rd_addr <= '0;
            wrap    <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            rd_addr <= addr_next;
            wrap    <= wrap_next;
            step_q  <= step;
        end
    end

endmodule

// File: rtl/ram_scanner.sv
// Dual-port RAM with an autonomous scanning read port; one-cycle registered read.
// Define RAM_SCANNER_BYPASS_EN for write-first collisions; otherwise collisions read-first.
module ram_scanner
    import ram_scan_pkg::*;
#(
    parameter  int DATA_W = 3,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              addr_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  mode_e             mode,
    input  logic              step,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wrap
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    // Addresses beyond DEPTH-1 are reachable when DEPTH is not a power of two; drop them.
    assign wr_ok = wr_en && !reset && (int'(wr_addr) < DEPTH);

    scan_addr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_seq (
        .addr_clk (addr_clk),
        .reset    (reset),
        .mode     (mode),
        .step     (step),
        .rd_addr  (rd_addr),
        .wrap     (wrap)
    );

    always_ff @(posedge addr_clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge addr_clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b1;
`ifdef RAM_SCANNER_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
`else
            rd_data  <= mem[rd_addr];
`endif
        end
    end

endmodule

// File: tb/tb_ram_scanner.sv
// Bench for ram_scanner: a DEPTH=32 and a DEPTH=10 instance checked against a queue-fed model.
module tb_ram_scanner;
    import ram_scan_pkg::*;

    localparam int DATA_W = 3;
    localparam int D0 = 32;
    localparam int A0 = 5;
    localparam int D1 = 10;
    localparam int A1 = 4;
    localparam int W  = 2 * (5 + DATA_W + 2);

    // clock / reset
    logic addr_clk = 1'b0;
    logic reset    = 1'b1;
    always #5 addr_clk = ~addr_clk;

    logic              wr_en0 = 1'b0, step0 = 1'b0;
    logic [A0-1:0]     wr_addr0 = '0;
    logic [DATA_W-1:0] wr_data0 = '0;
    mode_e             mode0 = MODE_HOLD;
    logic [A0-1:0]     rd_addr0;
    logic [DATA_W-1:0] rd_data0;
    logic              rd_valid0, wrap0;

    logic              wr_en1 = 1'b0, step1 = 1'b0;
    logic [A1-1:0]     wr_addr1 = '0;
    logic [DATA_W-1:0] wr_data1 = '0;
    mode_e             mode1 = MODE_HOLD;
    logic [A1-1:0]     rd_addr1;
    logic [DATA_W-1:0] rd_data1;
    logic              rd_valid1, wrap1;

    ram_scanner #(.DATA_W(DATA_W), .DEPTH(D0)) dut0 (
        .addr_clk (addr_clk), .reset (reset), .wr_en (wr_en0), .wr_addr (wr_addr0),
        .wr_data (wr_data0), .mode (mode0), .step (step0), .rd_addr (rd_addr0),
        .rd_data (rd_data0), .rd_valid (rd_valid0), .wrap (wrap0)
    );

    ram_scanner #(.DATA_W(DATA_W), .DEPTH(D1)) dut1 (
        .addr_clk (addr_clk), .reset (reset), .wr_en (wr_en1), .wr_addr (wr_addr1),
        .wr_data (wr_data1), .mode (mode1), .step (step1), .rd_addr (rd_addr1),
        .rd_data (rd_data1), .rd_valid (rd_valid1), .wrap (wrap1)
    );

    logic [W-1:0] dut_vec;
    assign dut_vec = {5'(rd_addr0), rd_data0, rd_valid0, wrap0,
                      5'(rd_addr1), rd_data1, rd_valid1, wrap1};

    // reference model state, one slot per instance
    int   m_addr [2];
    int   m_data [2];
    logic m_valid[2];
    logic m_wrap [2];
    logic m_stepq[2];
    int   m_mem  [2][32];

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Advance the model on the inputs present at the coming edge, then take the edge.
    task automatic tick();
        int dep[2];
        logic we[2];
        int wa[2];
        int wd[2];
        int md[2];
        logic st[2];
        int nxt;
        dep[0] = D0; we[0] = wr_en0; wa[0] = int'(wr_addr0); wd[0] = int'(wr_data0);
        md[0] = int'(mode0); st[0] = step0;
        dep[1] = D1; we[1] = wr_en1; wa[1] = int'(wr_addr1); wd[1] = int'(wr_data1);
        md[1] = int'(mode1); st[1] = step1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_addr[i] = 0; m_data[i] = 0; m_valid[i] = 1'b0;
                m_wrap[i] = 1'b0; m_stepq[i] = 1'b0;
            end else begin
                m_data[i] = m_mem[i][m_addr[i]];
`ifdef RAM_SCANNER_BYPASS_EN
                if (we[i] && wa[i] == m_addr[i]) m_data[i] = wd[i];
`endif
                if (we[i] && wa[i] < dep[i]) m_mem[i][wa[i]] = wd[i];
                nxt = m_addr[i];
                m_wrap[i] = 1'b0;
                if (md[i] == 1 || (md[i] == 3 && st[i] && !m_stepq[i])) begin
                    nxt = (m_addr[i] + 1) % dep[i];
                    m_wrap[i] = (nxt == 0);
                end else if (md[i] == 2) begin
                    nxt = (m_addr[i] + dep[i] - 1) % dep[i];
                    m_wrap[i] = (m_addr[i] == 0);
                end
                m_addr[i] = nxt;
                m_valid[i] = 1'b1;
                m_stepq[i] = st[i];
            end
        end
        exp_q.push_back({5'(m_addr[0]), 3'(m_data[0]), m_valid[0], m_wrap[0],
                         5'(m_addr[1]), 3'(m_data[1]), m_valid[1], m_wrap[1]});
        @(posedge addr_clk);
        #1;
    endtask

    // driver: tick without scoring the resulting cycle
    task automatic tick_quiet(input int n);
        logic [W-1:0] dropped;
        for (int i = 0; i < n; i++) begin
            tick();
            dropped = exp_q.pop_front();
        end
    endtask

    task automatic fill_memories();
        reset = 1'b0; mode0 = MODE_HOLD; mode1 = MODE_HOLD;
        for (int a = 0; a < D0; a++) begin
            wr_en0 = 1'b1; wr_addr0 = A0'(a); wr_data0 = DATA_W'($urandom_range(0, 7));
            wr_en1 = (a < D1); wr_addr1 = A1'(a % 16); wr_data1 = DATA_W'($urandom_range(0, 7));
            tick_quiet(1);
        end
        wr_en0 = 1'b0; wr_en1 = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp;
        reset = 1'b1;
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (dut_vec !== exp) begin
            errors++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp);
        end
        checks++;
        if ({rd_addr0, rd_data0, rd_valid0, wrap0} !== '0) begin
            errors++;
            $display("FAIL reset_values: got addr=%0d data=%0d valid=%b wrap=%b expected all 0",
                     rd_addr0, rd_data0, rd_valid0, wrap0);
        end
    endtask

    task automatic test_up_scan();
        logic [W-1:0] exp;
        reset = 1'b1; mode0 = MODE_UP;
        tick_quiet(1);
        reset = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp) begin
                errors++; $display("FAIL up_scan_model k=%0d: got %h expected %h", k, dut_vec, exp);
            end
            checks++;
            if (rd_addr0 !== A0'(k % 32) || wrap0 !== (k == 32) || rd_valid0 !== 1'b1) begin
                errors++;
                $display("FAIL up_scan k=%0d: got addr=%0d wrap=%b valid=%b expected addr=%0d wrap=%b valid=1",
                         k, rd_addr0, wrap0, rd_valid0, k % 32, (k == 32));
            end
        end
    endtask

    task automatic test_write_read();
        logic [W-1:0] exp;
        mode0 = MODE_HOLD;
        wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 3'b101;
        tick_quiet(1);
        wr_addr0 = 5'd6; wr_data0 = 3'b010;
        tick_quiet(1);
        wr_en0 = 1'b0; reset = 1'b1;
        tick_quiet(1);
        reset = 1'b0; mode0 = MODE_UP;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp) begin
                errors++; $display("FAIL write_read_model k=%0d: got %h expected %h", k, dut_vec, exp);
            end
            if (k == 6) begin
                checks++;
                if (rd_data0 !== 3'b101) begin
                    errors++; $display("FAIL read_addr5: got %b expected 101", rd_data0);
                end
            end
            if (k == 7) begin
                checks++;
                if (rd_data0 !== 3'b010) begin
                    errors++; $display("FAIL read_addr6: got %b expected 010", rd_data0);
                end
            end
        end
    endtask

    task automatic test_down_depth10();
        logic [W-1:0] exp;
        reset = 1'b1; mode1 = MODE_DOWN;
        tick_quiet(1);
        reset = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            wr_en1 = (k == 13); wr_addr1 = 4'd12; wr_data1 = DATA_W'($urandom_range(0, 7));
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp) begin
                errors++; $display("FAIL down10_model k=%0d: got %h expected %h", k, dut_vec, exp);
            end
            checks++;
            if (rd_addr1 !== A1'((10 - k % 10) % 10) || wrap1 !== (k % 10 == 1)) begin
                errors++;
                $display("FAIL down10 k=%0d: got addr=%0d wrap=%b expected addr=%0d wrap=%b",
                         k, rd_addr1, wrap1, (10 - k % 10) % 10, (k % 10 == 1));
            end
        end
        wr_en1 = 1'b0; mode1 = MODE_HOLD;
    endtask

    task automatic test_step();
        logic [W-1:0] exp;
        int pattern[8] = '{1, 1, 1, 1, 0, 0, 1, 0};
        int start;
        mode0 = MODE_STEP; step0 = 1'b0;
        tick_quiet(1);
        start = m_addr[0];
        for (int k = 0; k < 8; k++) begin
            step0 = pattern[k][0];
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp) begin
                errors++; $display("FAIL step_model k=%0d: got %h expected %h", k, dut_vec, exp);
            end
        end
        checks++;
        if (rd_addr0 !== A0'((start + 2) % 32)) begin
            errors++; $display("FAIL step_count: got addr=%0d expected %0d", rd_addr0, (start + 2) % 32);
        end
        mode0 = MODE_HOLD;
        for (int k = 0; k < 6; k++) begin
            step0 = k[0];
            tick_quiet(1);
        end
        // step high entering STEP must not advance
        step0 = 1'b1;
        tick_quiet(1);
        mode0 = MODE_STEP;
        tick_quiet(2);
        checks++;
        if (rd_addr0 !== A0'((start + 2) % 32)) begin
            errors++; $display("FAIL hold_and_entry: got addr=%0d expected %0d", rd_addr0, (start + 2) % 32);
        end
        step0 = 1'b0; mode0 = MODE_HOLD;
        tick_quiet(1);
    endtask

    task automatic test_collision();
        logic [W-1:0] exp;
        logic [DATA_W-1:0] want;
        mode0 = MODE_HOLD; reset = 1'b1;
        tick_quiet(1);
        reset = 1'b0;
        wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 3'b001;
        tick_quiet(1);
        wr_en0 = 1'b0; mode0 = MODE_UP;
        tick_quiet(7);
        mode0 = MODE_HOLD;
        wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 3'b110;
        tick();
`ifdef RAM_SCANNER_BYPASS_EN
        want = 3'b110;
`else
        want = 3'b001;
`endif
        exp = exp_q.pop_front();
        checks++;
        if (dut_vec !== exp) begin
            errors++; $display("FAIL collision_model: got %h expected %h", dut_vec, exp);
        end
        checks++;
        if (rd_addr0 !== 5'd7 || rd_data0 !== want) begin
            errors++; $display("FAIL collision: got addr=%0d data=%b expected addr=7 data=%b", rd_addr0, rd_data0, want);
        end
        wr_en0 = 1'b0;
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (rd_data0 !== 3'b110 || dut_vec !== exp) begin
            errors++; $display("FAIL collision_after: got data=%b expected 110", rd_data0);
        end
    endtask

    task automatic test_reset_midscan();
        logic [W-1:0] exp;
        logic [DATA_W-1:0] old3;
        reset = 1'b1; mode0 = MODE_UP;
        tick_quiet(1);
        reset = 1'b0;
        tick_quiet(20);
        old3 = 3'(m_mem[0][3]);
        reset = 1'b1; wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = ~old3;
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (dut_vec !== exp || {rd_addr0, rd_data0, rd_valid0, wrap0} !== '0) begin
            errors++;
            $display("FAIL midscan_reset: got addr=%0d data=%0d valid=%b wrap=%b expected all 0",
                     rd_addr0, rd_data0, rd_valid0, wrap0);
        end
        reset = 1'b0; wr_en0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp || rd_addr0 !== A0'(k)) begin
                errors++; $display("FAIL restart k=%0d: got addr=%0d expected %0d", k, rd_addr0, k);
            end
        end
        checks++;
        if (rd_data0 !== old3) begin
            errors++; $display("FAIL write_during_reset: got data=%b expected %b", rd_data0, old3);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp;
        for (int k = 0; k < 400; k++) begin
            reset    = ($urandom_range(0, 39) == 0);
            wr_en0   = $urandom_range(0, 1) == 1; wr_addr0 = A0'($urandom_range(0, 31));
            wr_data0 = DATA_W'($urandom_range(0, 7)); mode0 = mode_e'($urandom_range(0, 3));
            step0    = $urandom_range(0, 1) == 1;
            wr_en1   = $urandom_range(0, 1) == 1; wr_addr1 = A1'($urandom_range(0, 15));
            wr_data1 = DATA_W'($urandom_range(0, 7)); mode1 = mode_e'($urandom_range(0, 3));
            step1    = $urandom_range(0, 1) == 1;
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp) begin
                errors++; $display("FAIL random k=%0d: got %h expected %h", k, dut_vec, exp);
            end
        end
        reset = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = 0; m_data[i] = 0; m_valid[i] = 1'b0; m_wrap[i] = 1'b0; m_stepq[i] = 1'b0;
            for (int a = 0; a < 32; a++) m_mem[i][a] = 0;
        end
        @(negedge addr_clk);
        reset = 1'b1;
        tick_quiet(2);
        fill_memories();
        test_reset();
        test_up_scan();
        test_write_read();
        test_down_depth10();
        test_step();
        test_collision();
        test_reset_midscan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
